// File: rtl/tone_synth_ctrl.sv
// Key code to note frequency, with the square-wave tone synthesised by a fractional-N accumulator.
// Optional octave shift compiled in when TONE_OCTAVE_EN is defined.
module tone_synth_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int KEY_W       = 8,
  parameter int FREQ_W      = 9,
  parameter int NUM_KEYS    = 8,
  parameter int SUSTAIN_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_W-1:0]  buttons,
  input  logic [1:0]        octave,
  output logic              tone_out,
  output logic [FREQ_W+2:0] freq_out,
  output logic              active
);
  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int SUS_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'((SUSTAIN_CYC > 0) ? SUSTAIN_CYC - 1 : 0);
  localparam logic [ACC_W-1:0] HALF = ACC_W'(CLK_HZ / 2);
  localparam int TABLE_HZ [16] = '{0, 220, 247, 262, 294, 330, 349, 392, 440,
                                   0, 0, 0, 0, 0, 0, 0};

  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;

  state_t            state;
  logic [KEY_W-1:0]  key_q;
  logic [KEY_W-1:0]  cur_key;
  logic [1:0]        cur_oct;
  logic [1:0]        oct_sel;
  logic [ACC_W-1:0]  acc;
  logic [SUS_W-1:0]  sus_cnt;
  logic [FREQ_W-1:0] base_f;
  logic [FREQ_W+2:0] eff_f;
  logic              is_note;
  logic              new_note;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_next;
  logic              wrap;

`ifdef TONE_OCTAVE_EN
  logic [1:0] oct_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) oct_q <= 2'b0;
    else       oct_q <= octave;
  end
  assign oct_sel = oct_q;
`else
  logic unused_octave;
  assign unused_octave = ^octave;
  assign oct_sel = 2'b0;
`endif

  // Codes outside 1..NUM_KEYS, and table holes, read 0 and count as rest.
  always_comb begin
    base_f = '0;
    if (key_q != '0 && key_q <= KEY_W'(NUM_KEYS))
      base_f = FREQ_W'(TABLE_HZ[key_q[3:0]]);
  end

  assign eff_f    = (FREQ_W+3)'(base_f) << oct_sel;
  assign is_note  = (base_f != '0);
  assign new_note = (key_q != cur_key) || (oct_sel != cur_oct);

  // Phase step: wrapping at half the clock rate toggles the output, so the mean rate is exactly freq_out.
  assign acc_sum  = acc + ACC_W'(freq_out);
  assign wrap     = (acc_sum >= HALF);
  assign acc_next = wrap ? (acc_sum - HALF) : acc_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q    <= '0;
      cur_key  <= '0;
      cur_oct  <= 2'b0;
      state    <= IDLE;
      acc      <= '0;
      sus_cnt  <= '0;
      tone_out <= 1'b0;
      freq_out <= '0;
      active   <= 1'b0;
    end else begin
      key_q <= buttons;
      case (state)
        IDLE: begin
          if (is_note) begin
            state    <= PLAY;
            active   <= 1'b1;
            freq_out <= eff_f;
            cur_key  <= key_q;
            cur_oct  <= oct_sel;
            acc      <= '0;
            tone_out <= 1'b0;
          end
        end
        PLAY: begin
          if (is_note && new_note) begin
            freq_out <= eff_f;
            cur_key  <= key_q;
            cur_oct  <= oct_sel;
            acc      <= '0;
          end else if (is_note || SUSTAIN_CYC != 0) begin
            if (!is_note) begin
              state   <= SUSTAIN;
              sus_cnt <= '0;
            end
            acc <= acc_next;
            if (wrap) tone_out <= ~tone_out;
          end else begin
            state    <= IDLE;
            active   <= 1'b0;
            freq_out <= '0;
            acc      <= '0;
            tone_out <= 1'b0;
          end
        end
        SUSTAIN: begin
          if (is_note) begin
            state    <= PLAY;
            sus_cnt  <= '0;
            freq_out <= eff_f;
            cur_key  <= key_q;
            cur_oct  <= oct_sel;
            acc      <= '0;
          end else if (sus_cnt == SUS_LAST) begin
            state    <= IDLE;
            active   <= 1'b0;
            sus_cnt  <= '0;
            freq_out <= '0;
            acc      <= '0;
            tone_out <= 1'b0;
          end else begin
            sus_cnt <= sus_cnt + 1'b1;
            acc     <= acc_next;
            if (wrap) tone_out <= ~tone_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A note at or above half the clock rate cannot be represented by the accumulator.
  assert property (@(posedge clk) disable iff (reset) is_note |-> (ACC_W'(eff_f) < HALF));

endmodule
